axi4_rd_slave: RTL and testbench

- AXI4 read-channel responder (AR/R only) placed in front of a word-addressed synchronous memory (MROM/SRAM model). Its AR/R port connects directly to the instruction-fetch read master.
- Accepts one read request at a time and supports FIXED, INCR and WRAP bursts.
- Returns arlen+1 beats with an ID echo, rlast on the final beat, SLVERR on illegal requests, and a programmable first-beat latency.

---
 rtl/axi4_pkg.sv | 41 ++++
 rtl/axi4_rd_slave_if.sv | 26 ++
 rtl/axi4_burst_addr.sv | 24 ++
 rtl/axi4_rd_slave.sv | 144 ++++++++++++++
 tb/tb_axi4_rd_slave.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM states and the latched read-request record
// used by the read responder and the burst address generator.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        RESP
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        burst_e      burst;
    } ar_req_t;

    // A request is unserviceable when beats exceed the 32-bit bus, the burst
    // type is reserved, or a WRAP length is not a power-of-two beat count.
    function automatic logic req_err(input logic [7:0] len,
                                     input logic [2:0] size,
                                     input burst_e     burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi4_rd_slave_if.sv
// AR/R channel bundle between the instruction-fetch master and the read responder.
interface axi4_rd_slave_if;
    logic        in_arvalid;
    logic        in_arready;
    logic [31:0] in_araddr;
    logic [3:0]  in_arid;
    logic [7:0]  in_arlen;
    logic [2:0]  in_arsize;
    logic [1:0]  in_arburst;
    logic        in_rvalid;
    logic        in_rready;
    logic [31:0] in_rdata;
    logic [3:0]  in_rid;
    logic [1:0]  in_rresp;
    logic        in_rlast;

    modport slave (
        input  in_arvalid, in_araddr, in_arid, in_arlen, in_arsize, in_arburst, in_rready,
        output in_arready, in_rvalid, in_rdata, in_rid, in_rresp, in_rlast
    );

    modport master (
        output in_arvalid, in_araddr, in_arid, in_arlen, in_arsize, in_arburst, in_rready,
        input  in_arready, in_rvalid, in_rdata, in_rid, in_rresp, in_rlast
    );
endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts; shared by
// the read responder and the planned write responder.
module axi4_burst_addr
    import axi4_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [7:0]  len_i,
    input  burst_e      burst_i,
    output logic [31:0] next_addr_o
);
    logic [31:0] step;
    logic [31:0] wrap_mask;

    always_comb begin
        step      = 32'd1 << size_i;
        wrap_mask = (({24'd0, len_i} + 32'd1) << size_i) - 32'd1;
        case (burst_i)
            BURST_INCR: next_addr_o = addr_i + step;
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase
    end
endmodule

// File: rtl/axi4_rd_slave.sv
// AXI4 read-channel responder in front of a word-addressed synchronous memory:
// one burst at a time, programmable first-beat latency, SLVERR on bad requests.
module axi4_rd_slave
    import axi4_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          RD_LATENCY = 2,
    parameter int          MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    axi4_rd_slave_if.slave    axi,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata
);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  LAT_INIT  = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    state_e      state_q, state_d;
    ar_req_t     req_q, req_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        err_q, err_d;
    logic        beat_err_q, beat_err_d;
    logic        first_q, first_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic [31:0] offset;
    logic        beat_err;
    logic [31:0] next_addr;
    logic [31:0] rdata_out;
    logic        unused_offset_bits;

    axi4_burst_addr u_burst_addr (
        .addr_i      (req_q.addr),
        .size_i      (req_q.size),
        .len_i       (req_q.len),
        .burst_i     (req_q.burst),
        .next_addr_o (next_addr)
    );

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign offset             = req_q.addr - BASE_ADDR;
    assign beat_err           = err_q || (offset >= MEM_BYTES);
    assign mem_raddr          = offset[MEM_AW+1:2];
    assign unused_offset_bits = ^{offset[31:MEM_AW+2], offset[1:0]};

    // Memory data lands in the first RESP cycle; it is captured there and held afterwards.
    assign rdata_out = first_q ? (beat_err_q ? 32'd0 : mem_rdata) : rdata_q;

    assign axi.in_arready = !reset && (state_q == IDLE);
    assign axi.in_rvalid  = (state_q == RESP);
    assign axi.in_rdata   = rdata_out;
    assign axi.in_rid     = req_q.id;
    assign axi.in_rresp   = rresp_q;
    assign axi.in_rlast   = rlast_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        err_d      = err_q;
        beat_err_d = beat_err_q;
        first_d    = 1'b0;
        rdata_d    = rdata_out;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        mem_ren    = 1'b0;
        case (state_q)
            IDLE: begin
                if (axi.in_arvalid) begin
                    req_d = '{addr:  axi.in_araddr,
                              id:    axi.in_arid,
                              len:   axi.in_arlen,
                              size:  axi.in_arsize,
                              burst: burst_e'(axi.in_arburst)};
                    beat_cnt_d = 8'd0;
                    err_d      = req_err(axi.in_arlen, axi.in_arsize, burst_e'(axi.in_arburst));
                    if (RD_LATENCY == 0) begin
                        state_d = READ;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == 4'd0) state_d = READ;
                else                   lat_cnt_d = lat_cnt_q - 4'd1;
            end
            READ: begin
                mem_ren    = !beat_err;
                beat_err_d = beat_err;
                rresp_d    = beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d    = (beat_cnt_q == req_q.len);
                first_d    = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (axi.in_rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        req_d.addr = next_addr;
                        state_d    = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            beat_cnt_q <= 8'd0;
            lat_cnt_q  <= 4'd0;
            err_q      <= 1'b0;
            beat_err_q <= 1'b0;
            first_q    <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            err_q      <= err_d;
            beat_err_q <= beat_err_d;
            first_q    <= first_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end
endmodule

// File: tb/tb_axi4_rd_slave.sv
// Directed scoreboard bench for axi4_rd_slave: one instance with first-beat
// latency 2 and one with latency 0, each backed by a registered-read memory.
module tb_axi4_rd_slave;
    localparam logic [31:0] BASE = 32'h2000_0000;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hs_cyc = 0;
    int ren_cnt2 = 0;
    beat_t sbq[$];

    logic        sel;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;

    logic [31:0] mem [0:1023];
    logic        m2_ren, m0_ren;
    logic [9:0]  m2_raddr, m0_raddr;
    logic [31:0] m2_rdata, m0_rdata;

    axi4_rd_slave_if a2 ();
    axi4_rd_slave_if a0 ();

    assign a2.in_arvalid = arvalid && !sel;
    assign a0.in_arvalid = arvalid && sel;
    assign a2.in_araddr  = araddr;   assign a0.in_araddr  = araddr;
    assign a2.in_arid    = arid;     assign a0.in_arid    = arid;
    assign a2.in_arlen   = arlen;    assign a0.in_arlen   = arlen;
    assign a2.in_arsize  = arsize;   assign a0.in_arsize  = arsize;
    assign a2.in_arburst = arburst;  assign a0.in_arburst = arburst;
    assign a2.in_rready  = rready && !sel;
    assign a0.in_rready  = rready && sel;

    logic        arready_w, rvalid_w, rlast_w, ren_w;
    logic [31:0] rdata_w;
    logic [3:0]  rid_w;
    logic [1:0]  rresp_w;
    assign arready_w = sel ? a0.in_arready : a2.in_arready;
    assign rvalid_w  = sel ? a0.in_rvalid  : a2.in_rvalid;
    assign rlast_w   = sel ? a0.in_rlast   : a2.in_rlast;
    assign rdata_w   = sel ? a0.in_rdata   : a2.in_rdata;
    assign rid_w     = sel ? a0.in_rid     : a2.in_rid;
    assign rresp_w   = sel ? a0.in_rresp   : a2.in_rresp;
    assign ren_w     = sel ? m0_ren        : m2_ren;

    axi4_rd_slave #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .RD_LATENCY(2)) dut2 (
        .clock(clk), .reset(reset), .axi(a2),
        .mem_ren(m2_ren), .mem_raddr(m2_raddr), .mem_rdata(m2_rdata)
    );
    axi4_rd_slave #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .RD_LATENCY(0)) dut0 (
        .clock(clk), .reset(reset), .axi(a0),
        .mem_ren(m0_ren), .mem_raddr(m0_raddr), .mem_rdata(m0_rdata)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[4] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m2_ren) begin
            m2_rdata <= mem[m2_raddr];
            ren_cnt2 <= ren_cnt2 + 1;
        end
        if (m0_ren) m0_rdata <= mem[m0_raddr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step, bnd;
        step = 32'd1 << size;
        bnd  = (32'(len) + 32'd1) * step;
        case (burst)
            2'b01:   return a + step;
            2'b10:   return (a & ~(bnd - 32'd1)) | ((a + step) & (bnd - 32'd1));
            default: return a;
        endcase
    endfunction

    // Queues the expected beats, then presents AR until the handshake; called at a negedge.
    task automatic do_ar(input logic s, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic        rerr, berr;
        int          waitc;
        beat_t       e;
        a    = addr;
        rerr = (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        for (int b = 0; b <= int'(len); b++) begin
            berr   = rerr || ((a - BASE) >= 32'd4096);
            e.data = berr ? 32'd0 : mem[10'((a - BASE) >> 2)];
            e.id   = id;
            e.resp = berr ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            sbq.push_back(e);
            a = model_next(a, size, len, burst);
        end
        sel = s; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        waitc = 0;
        while (!arready_w && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!arready_w) check("ar_timeout", 32'(arready_w), 32'd1);
        hs_cyc = cyc;
        @(negedge clk);
        arvalid = 1'b0;
        $display("[TB] AR sel=%0d addr=%h id=%h len=%0d size=%0d burst=%0d", s, addr, id, len, size, burst);
    endtask

    // Consumes nbeats from the scoreboard; rready follows pat per valid cycle.
    task automatic collect(input int nbeats, input logic [3:0] pat, input int patlen, input int lat_exp);
        int    got, waitc, k;
        bit    first;
        beat_t e;
        got = 0; waitc = 0; k = 0; first = 1'b1;
        while (got < nbeats && waitc < 2000) begin
            @(negedge clk);
            waitc++;
            if (rvalid_w) begin
                if (first && lat_exp >= 0) check("first_beat_latency", 32'(cyc - hs_cyc), 32'(lat_exp));
                first  = 1'b0;
                rready = pat[k % patlen];
                k++;
                e = sbq[0];
                check("rdata", rdata_w, e.data);
                check("rid", 32'(rid_w), 32'(e.id));
                check("rresp", 32'(rresp_w), 32'(e.resp));
                check("rlast", 32'(rlast_w), 32'(e.last));
                check("arready_in_burst", 32'(arready_w), 32'd0);
                if (rready) begin
                    void'(sbq.pop_front());
                    got++;
                    $display("[TB] beat %0d data=%h id=%h resp=%0d last=%0b", got - 1, rdata_w, rid_w, rresp_w, rlast_w);
                end
            end else begin
                rready = 1'b0;
            end
        end
        if (got < nbeats) check("r_timeout", 32'(got), 32'(nbeats));
    endtask

    task automatic check_idle();
        @(negedge clk);
        rready = 1'b0;
        check("arready_after_last", 32'(arready_w), 32'd1);
        check("rvalid_after_last", 32'(rvalid_w), 32'd0);
    endtask

    initial begin
        int ren_before, waitc;
        reset = 1'b1; sel = 1'b0; arvalid = 1'b0; rready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (2) @(negedge clk);
        check("reset_arready", 32'(arready_w), 32'd0);
        check("reset_rvalid", 32'(rvalid_w), 32'd0);
        check("reset_rlast", 32'(rlast_w), 32'd0);
        check("reset_rresp", 32'(rresp_w), 32'd0);
        check("reset_rdata", rdata_w, 32'd0);
        check("reset_rid", 32'(rid_w), 32'd0);
        check("reset_mem_ren", 32'(ren_w), 32'd0);
        check("reset_rvalid_lat0", 32'(a0.in_rvalid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_arready", 32'(arready_w), 32'd1);

        // Single beat with 4-cycle first-beat latency
        do_ar(1'b0, 32'h2000_0010, 4'h3, 8'd0, 3'd2, 2'b01);
        collect(1, 4'b0001, 1, 4);
        check_idle();

        // INCR with backpressure 1,0,0,1
        do_ar(1'b0, 32'h2000_0000, 4'h1, 8'd3, 3'd2, 2'b01);
        collect(4, 4'b1001, 4, 4);
        check_idle();

        // WRAP: words 14,15,12,13
        do_ar(1'b0, 32'h2000_0038, 4'h5, 8'd3, 3'd2, 2'b10);
        collect(4, 4'b0001, 1, 4);
        check_idle();

        // Below-base address: all SLVERR, memory untouched
        ren_before = ren_cnt2;
        do_ar(1'b0, 32'h1000_0000, 4'h2, 8'd1, 3'd2, 2'b01);
        collect(2, 4'b0001, 1, -1);
        check("mem_ren_on_error", 32'(ren_cnt2 - ren_before), 32'd0);
        check_idle();

        // Last word then past the end
        do_ar(1'b0, 32'h2000_0FFC, 4'h6, 8'd1, 3'd2, 2'b01);
        collect(2, 4'b0001, 1, -1);
        check_idle();

        // Reserved burst type
        do_ar(1'b0, 32'h2000_0020, 4'h7, 8'd1, 3'd2, 2'b11);
        collect(2, 4'b0001, 1, -1);
        check_idle();

        // WRAP with an illegal length and an oversized beat
        do_ar(1'b0, 32'h2000_0020, 4'h8, 8'd2, 3'd2, 2'b10);
        collect(3, 4'b0101, 2, -1);
        check_idle();
        do_ar(1'b0, 32'h2000_0020, 4'h9, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b0001, 1, -1);
        check_idle();

        // Sub-word read returns the whole aligned word
        do_ar(1'b0, 32'h2000_0013, 4'hA, 8'd0, 3'd0, 2'b00);
        collect(1, 4'b0001, 1, 4);
        check_idle();

        // Reset during beat 2 of a len=7 burst
        do_ar(1'b0, 32'h2000_0040, 4'hC, 8'd7, 3'd2, 2'b01);
        collect(2, 4'b0001, 1, 4);
        waitc = 0;
        do begin
            @(negedge clk);
            rready = 1'b0;
            waitc++;
        end while (!rvalid_w && waitc < 20);
        check("beat2_rdata", rdata_w, sbq[0].data);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_rvalid", 32'(rvalid_w), 32'd0);
        check("midreset_arready", 32'(arready_w), 32'd0);
        reset = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("post_reset_arready", 32'(arready_w), 32'd1);
        check("post_reset_rvalid", 32'(rvalid_w), 32'd0);
        $display("[TB] reset applied mid-burst");
        do_ar(1'b0, 32'h2000_0008, 4'hF, 8'd0, 3'd2, 2'b01);
        collect(1, 4'b0001, 1, 4);
        check_idle();

        // Zero latency, 256-beat FIXED burst
        do_ar(1'b1, 32'h2000_0020, 4'hB, 8'd255, 3'd2, 2'b00);
        collect(256, 4'b0001, 1, 2);
        check_idle();
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
